// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: word widths,
// loader state encodings and the Inst_mem write-port bundle.
package inst_loader_pkg;

  // Instruction word and Inst_mem byte-address widths
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  // Loader state encodings
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_FILL = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd3;
  localparam logic [2:0] ST_RUN  = 3'd4;

  // One registered write-port beat towards Inst_mem
  typedef struct packed {
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] data;
  } wr_port_t;

  // Word index to byte address; the two low bits are always zero
  function automatic logic [ADDR_W-1:0] word_to_byte_addr(input logic [ADDR_W-1:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Bundle of the instruction stream handshake and the Inst_mem write port.
// The slave side is the loader; the master side is the boot source that
// drives the stream and observes the memory writes.
interface inst_loader_if;
  import inst_loader_pkg::*;

  // Instruction stream
  logic              s_valid;
  logic [INST_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;

  // Inst_mem write port (wr_en also selects the memory address mux)
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [INST_W-1:0] Inst_i;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready,
    input  wr_en,
    input  addr,
    input  Inst_i
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready,
    output wr_en,
    output addr,
    output Inst_i
  );

endinterface

// File: rtl/inst_loader_hold_timer.sv
// Settle timer for the CPU reset hold. Loaded when the loader enters HOLD;
// reports expiry once it has counted all the way down to zero, so the
// loader leaves HOLD CYCLES+1 edges after the load.
module hold_timer
  import inst_loader_pkg::*;
#(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_expired
);

  localparam int TW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

  logic [TW-1:0] r_count;

  // Reload on entry to HOLD, otherwise count down and stop at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= TW'(CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - TW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/inst_loader.sv
// Boot-time instruction loader. Accepts a valid/ready word stream, writes
// it to consecutive Inst_mem word addresses, zero-fills the remainder of
// the memory, holds the CPU pipeline in reset for a settle time and then
// releases rst_n_cpu. A start pulse in RUN reloads the whole program.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int HOLD_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  inst_loader_if.slave bus,
  output logic         rst_n_cpu,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // Registered state
  logic [2:0]    r_state;
  logic [AW-1:0] r_cnt;
  wr_port_t      r_wr;
  logic          r_rst_n_cpu;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  // Next-state / decode wires
  logic [2:0]    w_state_next;
  logic [AW-1:0] w_cnt_next;
  wr_port_t      w_wr_next;
  logic          w_err_next;
  logic          w_busy_next;
  logic          w_run_next;
  logic          w_s_ready;
  logic          w_handshake;
  logic          w_hold_load;
  logic          w_hold_expired;

  // Ready decodes the registered state only, so s_valid never loops back
  assign w_s_ready   = (r_state == ST_LOAD);
  assign w_handshake = bus.s_valid & w_s_ready;

  // Arm the settle timer on the edge that enters HOLD
  assign w_hold_load = (w_state_next == ST_HOLD) && (r_state != ST_HOLD);

  hold_timer #(
    .CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_hold_load),
    .o_expired (w_hold_expired)
  );

  // Loader FSM: next state, word counter, write-port beat and error flag
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_err_next      = r_err;
    w_wr_next.wr_en = 1'b0;
    w_wr_next.addr  = r_wr.addr;
    w_wr_next.data  = r_wr.data;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_LOAD;
          w_cnt_next   = '0;
          w_err_next   = 1'b0;
        end
      end

      ST_LOAD: begin
        if (w_handshake) begin
          w_wr_next.wr_en = 1'b1;
          w_wr_next.addr  = word_to_byte_addr(ADDR_W'(r_cnt));
          w_wr_next.data  = bus.s_data;
          w_cnt_next      = r_cnt + AW'(1);
          if (r_cnt == LAST_IDX) begin
            // Memory is full: the program either ended exactly here or was cut
            w_state_next = ST_HOLD;
            if (!bus.s_last) begin
              w_err_next = 1'b1;
            end
          end else if (bus.s_last) begin
            w_state_next = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        // One zero word per cycle up to and including the top word
        w_wr_next.wr_en = 1'b1;
        w_wr_next.addr  = word_to_byte_addr(ADDR_W'(r_cnt));
        w_wr_next.data  = '0;
        w_cnt_next      = r_cnt + AW'(1);
        if (r_cnt == LAST_IDX) begin
          w_state_next = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (w_hold_expired) begin
          w_state_next = ST_RUN;
        end
      end

      ST_RUN: begin
        if (start) begin
          w_state_next = ST_LOAD;
          w_cnt_next   = '0;
          w_err_next   = 1'b0;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Status outputs follow the state being entered, so they change on the
  // same edge as the state itself
  always_comb begin
    w_busy_next = (w_state_next == ST_LOAD) ||
                  (w_state_next == ST_FILL) ||
                  (w_state_next == ST_HOLD);
    w_run_next  = (w_state_next == ST_RUN);
  end

  // State and output registers; reset forces the CPU back into reset at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_wr        <= '0;
      r_rst_n_cpu <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_wr        <= w_wr_next;
      r_rst_n_cpu <= w_run_next;
      r_busy      <= w_busy_next;
      r_done      <= w_run_next;
      r_err       <= w_err_next;
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.wr_en    = r_wr.wr_en;
  assign bus.addr     = r_wr.addr;
  assign bus.Inst_i   = r_wr.data;
  assign rst_n_cpu    = r_rst_n_cpu;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;

endmodule
